// File: rtl/paddle_centroid_tracker_if.sv
// Pixel-stream and centroid-result bundle for paddle_centroid_tracker.
// The pixel source is the master; the tracker is the slave.
interface paddle_centroid_tracker_if;
  logic        pix_valid;
  logic [1:0]  color_code;
  logic [12:0] row;
  logic [12:0] col;
  logic [12:0] c1_x;
  logic [12:0] c1_y;
  logic [12:0] c2_x;
  logic [12:0] c2_y;
  logic        c1_found;
  logic        c2_found;
  logic        loc_valid;
  logic        busy;
  logic        overrun;

  modport master (
    output pix_valid, color_code, row, col,
    input  c1_x, c1_y, c2_x, c2_y, c1_found, c2_found, loc_valid, busy, overrun
  );

  modport slave (
    input  pix_valid, color_code, row, col,
    output c1_x, c1_y, c2_x, c2_y, c1_found, c2_found, loc_valid, busy, overrun
  );
endinterface

// File: rtl/paddle_centroid_tracker.sv
// Per-frame two-color centroid tracker: accumulates counts and coordinate sums,
// snapshots them at frame end and divides them with one shared restoring divider.
module paddle_centroid_tracker #(
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 19,
  parameter int SUM_W      = 28
) (
  input  logic                       clk,
  input  logic                       reset,
  paddle_centroid_tracker_if.slave   bus
);
  // state  | meaning
  // IDLE   | waiting for a frame end
  // DIV    | one operand-load cycle, then four divisions of SUM_W steps each
  // DONE   | outputs just updated, loc_valid high for this cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [12:0] W_LIM    = 13'(FRAME_W);
  localparam logic [12:0] H_LIM    = 13'(FRAME_H);
  localparam logic [12:0] LAST_COL = 13'(FRAME_W - 1);
  localparam logic [12:0] LAST_ROW = 13'(FRAME_H - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam logic [STEP_W-1:0] STEPS = STEP_W'(SUM_W);

  logic             accept, frame_end, is_c1, is_c2;
  logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt1_d, cnt2_d, scnt1_q, scnt2_q;
  logic [SUM_W-1:0] sx1_q, sy1_q, sx2_q, sy2_q, sx1_d, sy1_d, sx2_d, sy2_d;
  logic [SUM_W-1:0] ssx1_q, ssy1_q, ssx2_q, ssy2_q;

  logic [1:0]        state_q, idx_q, nidx;
  logic              ld_q;
  logic [STEP_W-1:0] step_q;
  logic [SUM_W-1:0]  rem_q, quo_q, rem_nx, quo_nx, dvd_sel;
  logic [CNT_W-1:0]  den_q, dvs_sel;
  logic [SUM_W:0]    rem_sh, den_ext;
  logic              ge, found1, found2;
  logic [12:0]       res0_q, res1_q, res2_q;
  logic [12:0]       c1_x_q, c1_y_q, c2_x_q, c2_y_q;
  logic              c1_found_q, c2_found_q, overrun_q;

  always_comb begin
    accept    = bus.pix_valid && (bus.row < H_LIM) && (bus.col < W_LIM);
    frame_end = accept && (bus.row == LAST_ROW) && (bus.col == LAST_COL);
    is_c1     = accept && (bus.color_code == 2'b01);
    is_c2     = accept && (bus.color_code == 2'b10);
    cnt1_d    = is_c1 ? cnt1_q + CNT_W'(1)       : cnt1_q;
    sx1_d     = is_c1 ? sx1_q + SUM_W'(bus.col)  : sx1_q;
    sy1_d     = is_c1 ? sy1_q + SUM_W'(bus.row)  : sy1_q;
    cnt2_d    = is_c2 ? cnt2_q + CNT_W'(1)       : cnt2_q;
    sx2_d     = is_c2 ? sx2_q + SUM_W'(bus.col)  : sx2_q;
    sy2_d     = is_c2 ? sy2_q + SUM_W'(bus.row)  : sy2_q;
  end

  // Operand select for the division that starts next.
  always_comb begin
    nidx = ld_q ? 2'd0 : idx_q + 2'd1;
    case (nidx)
      2'd0:    begin dvd_sel = ssx1_q; dvs_sel = scnt1_q; end
      2'd1:    begin dvd_sel = ssy1_q; dvs_sel = scnt1_q; end
      2'd2:    begin dvd_sel = ssx2_q; dvs_sel = scnt2_q; end
      default: begin dvd_sel = ssy2_q; dvs_sel = scnt2_q; end
    endcase
  end

  // One restoring step; a zero divisor yields all-ones, masked later by found.
  always_comb begin
    rem_sh  = {rem_q, quo_q[SUM_W-1]};
    den_ext = (SUM_W + 1)'(den_q);
    ge      = rem_sh >= den_ext;
    rem_nx  = ge ? SUM_W'(rem_sh - den_ext) : rem_sh[SUM_W-1:0];
    quo_nx  = {quo_q[SUM_W-2:0], ge};
    found1  = (scnt1_q != '0) && (scnt1_q >= MIN_CNT);
    found2  = (scnt2_q != '0) && (scnt2_q >= MIN_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1_q <= '0; sx1_q <= '0; sy1_q <= '0; cnt2_q <= '0; sx2_q <= '0; sy2_q <= '0;
      scnt1_q <= '0; ssx1_q <= '0; ssy1_q <= '0; scnt2_q <= '0; ssx2_q <= '0; ssy2_q <= '0;
      state_q <= S_IDLE; ld_q <= 1'b0; idx_q <= '0; step_q <= '0;
      rem_q <= '0; quo_q <= '0; den_q <= '0;
      res0_q <= '0; res1_q <= '0; res2_q <= '0;
      c1_x_q <= '0; c1_y_q <= '0; c2_x_q <= '0; c2_y_q <= '0;
      c1_found_q <= 1'b0; c2_found_q <= 1'b0; overrun_q <= 1'b0;
    end else begin
      if (frame_end) begin
        cnt1_q <= '0; sx1_q <= '0; sy1_q <= '0; cnt2_q <= '0; sx2_q <= '0; sy2_q <= '0;
        if (state_q == S_IDLE) begin
          scnt1_q <= cnt1_d; ssx1_q <= sx1_d; ssy1_q <= sy1_d;
          scnt2_q <= cnt2_d; ssx2_q <= sx2_d; ssy2_q <= sy2_d;
        end else begin
          overrun_q <= 1'b1;
        end
      end else begin
        cnt1_q <= cnt1_d; sx1_q <= sx1_d; sy1_q <= sy1_d;
        cnt2_q <= cnt2_d; sx2_q <= sx2_d; sy2_q <= sy2_d;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_end) begin
            state_q <= S_DIV;
            ld_q    <= 1'b1;
          end
        end
        S_DIV: begin
          if (ld_q || (step_q == STEP_W'(1) && idx_q != 2'd3)) begin
            if (!ld_q) begin
              case (idx_q)
                2'd0:    res0_q <= 13'(quo_nx);
                2'd1:    res1_q <= 13'(quo_nx);
                default: res2_q <= 13'(quo_nx);
              endcase
            end
            ld_q   <= 1'b0;
            idx_q  <= nidx;
            rem_q  <= '0;
            quo_q  <= dvd_sel;
            den_q  <= dvs_sel;
            step_q <= STEPS;
          end else begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            step_q <= step_q - STEP_W'(1);
            if (step_q == STEP_W'(1)) begin
              state_q    <= S_DONE;
              c1_x_q     <= found1 ? res0_q : 13'd0;
              c1_y_q     <= found1 ? res1_q : 13'd0;
              c2_x_q     <= found2 ? res2_q : 13'd0;
              c2_y_q     <= found2 ? 13'(quo_nx) : 13'd0;
              c1_found_q <= found1;
              c2_found_q <= found2;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.c1_x      = c1_x_q;
  assign bus.c1_y      = c1_y_q;
  assign bus.c2_x      = c2_x_q;
  assign bus.c2_y      = c2_y_q;
  assign bus.c1_found  = c1_found_q;
  assign bus.c2_found  = c2_found_q;
  assign bus.loc_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_paddle_centroid_tracker.sv
// Self-checking bench for paddle_centroid_tracker on an 8x4 frame: fixed vectors,
// random frames against an arithmetic model, overrun and reset sequences.
module tb_paddle_centroid_tracker;
  localparam int FW = 8, FH = 4, MINP = 2, CW = 6, SW = 8;
  localparam int LAT = 4 * SW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  paddle_centroid_tracker_if bus();
  paddle_centroid_tracker #(.FRAME_W(FW), .FRAME_H(FH), .MIN_PIXELS(MINP),
                            .CNT_W(CW), .SUM_W(SW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [63:0] f;
    logic [53:0] exp;
  } vec_t;

  int cyc = 0;
  int errors = 0, checks = 0;
  int lv_count = 0, lv_cyc = 0;
  logic [53:0] lv_outs = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [53:0] outs();
    return {bus.c1_x, bus.c1_y, bus.c1_found, bus.c2_x, bus.c2_y, bus.c2_found};
  endfunction

  always @(negedge clk) begin
    if (bus.loc_valid) begin
      lv_count <= lv_count + 1;
      lv_cyc   <= cyc;
      lv_outs  <= outs();
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] put(logic [63:0] f, int r, int c, logic [1:0] v);
    f[2*(r*FW+c) +: 2] = v;
    return f;
  endfunction

  function automatic logic [53:0] pack(int x1, int y1, int f1, int x2, int y2, int f2);
    return {13'(x1), 13'(y1), 1'(f1), 13'(x2), 13'(y2), 1'(f2)};
  endfunction

  // Reference: counts and coordinate sums per color, floor mean, gated by MINP.
  function automatic logic [53:0] model(logic [63:0] f);
    int n[2], sx[2], sy[2], x[2], y[2], fd[2];
    for (int k = 0; k < 2; k++) begin n[k] = 0; sx[k] = 0; sy[k] = 0; end
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++) begin
        logic [1:0] v;
        v = f[2*(r*FW+c) +: 2];
        if (v == 2'b01 || v == 2'b10) begin
          n[v-1]++; sx[v-1] += c; sy[v-1] += r;
        end
      end
    for (int k = 0; k < 2; k++) begin
      fd[k] = (n[k] >= MINP && n[k] > 0) ? 1 : 0;
      x[k]  = fd[k] ? sx[k] / n[k] : 0;
      y[k]  = fd[k] ? sy[k] / n[k] : 0;
    end
    return pack(x[0], y[0], fd[0], x[1], y[1], fd[1]);
  endfunction

  function automatic logic [63:0] rand_frame();
    logic [63:0] f;
    int d1, d2, p;
    d1 = $urandom_range(0, 30);
    d2 = $urandom_range(0, 30);
    f = '0;
    for (int i = 0; i < FW*FH; i++) begin
      p = $urandom_range(0, 99);
      if (p < d1)               f[2*i +: 2] = 2'b01;
      else if (p < d1 + d2)     f[2*i +: 2] = 2'b10;
      else if (p < d1 + d2 + 8) f[2*i +: 2] = 2'b11;
    end
    return f;
  endfunction

  task automatic idle_in();
    bus.pix_valid  = 1'b0;
    bus.color_code = 2'($urandom_range(0, 3));
    bus.row        = 13'($urandom_range(0, 8191));
    bus.col        = 13'($urandom_range(0, 8191));
  endtask

  task automatic stray_in();
    bus.pix_valid  = 1'b1;
    bus.color_code = 2'b01;
    if ($urandom_range(0, 1) == 1) begin
      bus.row = 13'(FH); bus.col = 13'(FW - 1);
    end else begin
      bus.row = 13'(FH - 1); bus.col = 13'(FW);
    end
  endtask

  task automatic drive_frame(input logic [63:0] f, input bit noisy, output int t_end);
    t_end = 0;
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++) begin
        if (noisy)
          while ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) stray_in(); else idle_in();
          end
        @(posedge clk); #1;
        bus.pix_valid  = 1'b1;
        bus.row        = 13'(r);
        bus.col        = 13'(c);
        bus.color_code = f[2*(r*FW+c) +: 2];
        if (r == FH-1 && c == FW-1) t_end = cyc;
      end
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic expect_result(input string name, input logic [53:0] exp,
                               input int t_end, input int n0);
    int k;
    k = 0;
    while (lv_count == n0 && k < LAT + 40) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk({name, " pulses"}, 64'(lv_count - n0), 64'd1);
    if (lv_count != n0) begin
      chk({name, " latency"}, 64'(lv_cyc - t_end), 64'(LAT));
      chk({name, " result"}, 64'(lv_outs), 64'(exp));
    end
    chk({name, " hold"}, 64'(outs()), 64'(exp));
    chk({name, " busy_idle"}, 64'(bus.busy), 64'd0);
  endtask

  vec_t tv [6];
  int t, t2, n0;
  logic [63:0] fa, fb, fr;

  initial begin
    tv[0].f = '0;
    tv[0].f = put(tv[0].f, 1, 2, 2'b01); tv[0].f = put(tv[0].f, 1, 4, 2'b01);
    tv[0].f = put(tv[0].f, 2, 2, 2'b01); tv[0].f = put(tv[0].f, 2, 4, 2'b01);
    tv[0].exp = pack(3, 1, 1, 0, 0, 0);
    tv[1].f = put(tv[0].f, 3, 7, 2'b10);
    tv[1].f = put(tv[1].f, 0, 0, 2'b11); tv[1].f = put(tv[1].f, 3, 0, 2'b11);
    tv[1].f = put(tv[1].f, 2, 3, 2'b11);
    tv[1].exp = pack(3, 1, 1, 0, 0, 0);
    tv[2].f = put(64'd0, 0, 1, 2'b01); tv[2].f = put(tv[2].f, 0, 2, 2'b01);
    tv[2].exp = pack(1, 0, 1, 0, 0, 0);
    tv[3].f = put(64'd0, 0, 0, 2'b01);
    tv[3].f = put(tv[3].f, 3, 5, 2'b10); tv[3].f = put(tv[3].f, 3, 7, 2'b10);
    tv[3].exp = pack(0, 0, 0, 6, 3, 1);
    tv[4].f = '0;
    tv[4].exp = pack(0, 0, 0, 0, 0, 0);
    tv[5].f = put(64'd0, 3, 7, 2'b01); tv[5].f = put(tv[5].f, 0, 0, 2'b01);
    tv[5].f = put(tv[5].f, 0, 7, 2'b01);
    tv[5].f = put(tv[5].f, 1, 1, 2'b10); tv[5].f = put(tv[5].f, 2, 2, 2'b10);
    tv[5].f = put(tv[5].f, 3, 3, 2'b10);
    tv[5].exp = pack(4, 1, 1, 2, 2, 1);

    reset = 1'b1;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'({outs(), bus.loc_valid, bus.busy, bus.overrun}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      n0 = lv_count;
      drive_frame(tv[i].f, (i % 2) == 1, t);
      if (i == 0) chk("busy_in_div", 64'(bus.busy), 64'd1);
      expect_result($sformatf("vec%0d", i), tv[i].exp, t, n0);
    end

    for (int i = 0; i < 8; i++) begin
      fr = rand_frame();
      n0 = lv_count;
      drive_frame(fr, 1'b1, t);
      expect_result($sformatf("rand%0d", i), model(fr), t, n0);
    end

    // Out-of-range pixels alone must neither count nor end a frame.
    n0 = lv_count;
    @(posedge clk); #1; bus.pix_valid = 1'b1; bus.color_code = 2'b01;
    bus.row = 13'(FH); bus.col = 13'(FW - 1);
    @(posedge clk); #1; bus.row = 13'(FH - 1); bus.col = 13'(FW);
    @(posedge clk); #1; idle_in();
    repeat (LAT + 10) @(negedge clk);
    chk("stray_no_pulse", 64'(lv_count - n0), 64'd0);
    chk("stray_no_busy", 64'(bus.busy), 64'd0);
    n0 = lv_count;
    drive_frame(tv[2].f, 1'b0, t);
    expect_result("after_stray", tv[2].exp, t, n0);

    // Back-to-back frames: second frame end lands while dividing.
    chk("overrun_clear", 64'(bus.overrun), 64'd0);
    fa = rand_frame();
    fb = rand_frame();
    n0 = lv_count;
    drive_frame(fa, 1'b0, t);
    chk("overrun_before", 64'(bus.overrun), 64'd0);
    drive_frame(fb, 1'b0, t2);
    expect_result("overrun_first", model(fa), t, n0);
    chk("overrun_set", 64'(bus.overrun), 64'd1);
    fr = rand_frame();
    n0 = lv_count;
    drive_frame(fr, 1'b1, t);
    expect_result("after_overrun", model(fr), t, n0);
    chk("overrun_sticky", 64'(bus.overrun), 64'd1);

    // Reset in the middle of a division.
    n0 = lv_count;
    drive_frame(tv[5].f, 1'b0, t);
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    chk("rst_div_no_pulse", 64'(lv_count - n0), 64'd0);
    chk("rst_div_outs", 64'({outs(), bus.busy, bus.overrun}), 64'd0);
    fr = rand_frame();
    n0 = lv_count;
    drive_frame(fr, 1'b1, t);
    expect_result("after_rst_div", model(fr), t, n0);

    // Reset mid-frame: partial color-1 data must not leak into the next frame.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.pix_valid = 1'b1; bus.color_code = 2'b01;
      bus.row = 13'(i / FW); bus.col = 13'(i % FW);
    end
    @(posedge clk); #1; idle_in(); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    n0 = lv_count;
    drive_frame(tv[3].f, 1'b0, t);
    expect_result("after_rst_frame", tv[3].exp, t, n0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/paddle_centroid_tracker.md
PADDLE_CENTROID_TRACKER -- requirements
Module: paddle_centroid_tracker

Interface
REQ-001 SHALL have parameter FRAME_W, default 640, active pixel columns per frame.
REQ-002 SHALL have parameter FRAME_H, default 480, active pixel rows per frame.
REQ-003 SHALL have parameter MIN_PIXELS, default 16, minimum per-color pixel count for a valid detection.
REQ-004 SHALL have parameter CNT_W, default 19, per-color pixel counter width; must hold FRAME_W*FRAME_H.
REQ-005 SHALL have parameter SUM_W, default 28, per-color coordinate-sum width; must hold (FRAME_W-1)*FRAME_W*FRAME_H.
REQ-006 SHALL have clk, input, 1, sole clock; all logic on the rising edge.
REQ-007 SHALL have reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have pix_valid, input, 1, qualifies color_code/row/col this cycle.
REQ-009 SHALL have color_code, input, 2, denoised mask code: 00 none, 01 color 1, 10 color 2, 11 ambiguous.
REQ-010 SHALL have row and col, input, 13 each, coordinates of the current pixel.
REQ-011 SHALL have c1_x, c1_y, c2_x, c2_y, output, 13 each, registered per-color centroids.
REQ-012 SHALL have c1_found and c2_found, output, 1 each, per-color detection flags.
REQ-013 SHALL have loc_valid, output, 1, one-cycle pulse when all centroid outputs update.
REQ-014 SHALL have busy, output, 1, high while a division is in progress.
REQ-015 SHALL have overrun, output, 1, sticky flag set when a frame result is dropped.

Function
REQ-016 SHALL accept a pixel only if pix_valid=1, row<FRAME_H and col<FRAME_W; all other cycles leave the accumulators unchanged.
REQ-017 SHALL, for each accepted pixel with code 01 (color 1) or 10 (color 2), add 1 to that color's count, col to its sum_x and row to its sum_y; code 00 and 11 SHALL change nothing.
REQ-018 SHALL treat the accepted pixel at row=FRAME_H-1, col=FRAME_W-1 as frame end (cycle T).
REQ-019 SHALL, at frame end, include that pixel, copy all six accumulators into snapshot registers on the same edge, and clear the accumulators so the next frame starts from zero.
REQ-020 SHALL use FSM states IDLE, DIV, DONE: IDLE->DIV at frame end; DIV runs four sequential restoring divisions (sum_x1, sum_y1, sum_x2, sum_y2 by their counts) of exactly SUM_W cycles each; DIV->DONE after the fourth; DONE->IDLE after one cycle.
REQ-021 SHALL compute each centroid as floor(sum/count), truncated to 13 bits.
REQ-022 SHALL skip no division steps when count is 0; a zero divisor SHALL produce centroid 0 and found=0, with no X propagation.
REQ-023 SHALL set cN_found=1 iff the snapshot count for color N is >= MIN_PIXELS; otherwise cN_x=cN_y=0.
REQ-024 SHALL update all six centroid outputs together and pulse loc_valid for exactly one cycle in state DONE, at cycle T+4*SUM_W+2.
REQ-025 SHALL hold centroid and found outputs constant between loc_valid pulses.
REQ-026 SHALL drive busy=1 in DIV and DONE, 0 in IDLE.
REQ-027 SHALL keep accumulating the next frame while busy=1.
REQ-028 SHALL, on a frame end while busy=1, clear the accumulators, discard the new snapshot, leave the division in progress undisturbed, and set overrun=1.
REQ-029 SHALL never wrap any counter or sum within one frame, given the REQ-004/REQ-005 width constraints.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, clear all accumulators, snapshots and divider state, enter IDLE, and drive all outputs to 0 on the following cycle.
REQ-031 SHALL, on reset asserted mid-frame or mid-division, abandon that frame with no loc_valid pulse; the first frame end after reset deasserts starts a fresh computation.

Verification
REQ-032 SHALL cover: FRAME_W=8, FRAME_H=4, MIN_PIXELS=2; color 1 at (row,col) (1,2),(1,4),(2,2),(2,4); rest 00 -> c1_x=3, c1_y=1, c1_found=1, c2_found=0, loc_valid at T+4*SUM_W+2.
REQ-033 SHALL cover: same frame plus one color-2 pixel at (3,7) -> c2_found=0, c2_x=c2_y=0; both colors unaffected by code-11 pixels.
REQ-034 SHALL cover: color 1 at cols 1 and 2, row 0 -> c1_x=1 (floor of 1.5).
REQ-035 SHALL cover: second frame end while busy -> overrun=1, exactly one loc_valid pulse, outputs carry first frame's result.
REQ-036 SHALL cover: reset during DIV -> no loc_valid, outputs 0; next full frame yields correct centroids.
REQ-037 SHALL cover: pix_valid=1 with row=FRAME_H or col=FRAME_W and code 01 -> no count change and no frame-end trigger.
